// File: rtl/key_debounce.sv
// Four-channel active-low key synchroniser, debouncer and press-pulse generator.
// Define KEY_FAST_SIM_EN to force a 16-cycle debounce threshold for simulation.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  output logic [3:0] key_out
);

`ifdef KEY_FAST_SIM_EN
  localparam int unsigned THRESH = 16;
`else
  localparam int unsigned THRESH = DEBOUNCE_CYCLES;
`endif
  localparam int unsigned CW = $clog2(THRESH);
  localparam logic [CW-1:0] CNT_MAX = CW'(THRESH - 1);

  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [3:0]    stable_q, stable_d;
  logic [3:0]    stable_prev_q, stable_prev_d;
  logic [3:0]    key_out_q, key_out_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];

  always_comb begin
    sync1_d       = key;
    sync2_d       = sync1_q;
    stable_prev_d = stable_q;
    stable_d      = stable_q;
    // Press pulse is the falling edge of the accepted level.
    key_out_d     = stable_prev_q & ~stable_q;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '1;
      sync2_q       <= '1;
      stable_q      <= '1;
      stable_prev_q <= '1;
      key_out_q     <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      key_out_q     <= key_out_d;
      for (int unsigned i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign key_out = key_out_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed-vector bench for key_debounce with a 16-cycle debounce threshold.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key = 4'b1111;
  logic [3:0] key_out;

  int checks = 0;
  int errors = 0;

  key_debounce #(.DEBOUNCE_CYCLES(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key     (key),
    .key_out (key_out)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [3:0] key;
    int         cycles;
    logic [3:0] exp_val;
    int         exp_cnt;
    int         exp_dly;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Called at a negedge; cycle c is observed at the negedge after the c-th posedge.
  task automatic run_phase(input logic [3:0] k, input int n,
                           output int npulse, output logic [3:0] pval, output int dly);
    key    = k;
    npulse = 0;
    pval   = '0;
    dly    = -1;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (key_out !== 4'b0000) begin
        npulse++;
        pval |= key_out;
        if (dly < 0) dly = c - 1;
      end
    end
  endtask

  initial begin
    int         np, dl, tot;
    logic [3:0] pv;

    vecs[0] = '{4'b1111, 25, 4'b0000, 0, -1};
    vecs[1] = '{4'b1011, 50, 4'b0100, 1, 18};
    vecs[2] = '{4'b1111, 25, 4'b0000, 0, -1};
    vecs[3] = '{4'b1101, 50, 4'b0010, 1, 18};
    vecs[4] = '{4'b1111, 25, 4'b0000, 0, -1};
    vecs[5] = '{4'b0000, 30, 4'b1111, 1, 18};
    vecs[6] = '{4'b1111, 25, 4'b0000, 0, -1};

    #123;
    chk("reset_key_out", int'(key_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_phase(vecs[v].key, vecs[v].cycles, np, pv, dl);
      chk($sformatf("vec%0d_count", v), np, vecs[v].exp_cnt);
      chk($sformatf("vec%0d_value", v), int'(pv), int'(vecs[v].exp_val));
      chk($sformatf("vec%0d_delay", v), dl, vecs[v].exp_dly);
    end

    // Bounce on key[0]: short lows never accepted, then a real press.
    tot = 0;
    for (int r = 0; r < 5; r++) begin
      run_phase(4'b1110, 10, np, pv, dl);
      tot += np;
      run_phase(4'b1111, 10, np, pv, dl);
      tot += np;
    end
    chk("bounce_no_pulse", tot, 0);
    run_phase(4'b1110, 30, np, pv, dl);
    chk("bounce_hold_count", np, 1);
    chk("bounce_hold_value", int'(pv), 1);
    chk("bounce_hold_delay", dl, 18);
    run_phase(4'b1111, 25, np, pv, dl);
    chk("bounce_release", np, 0);

    // Reset mid-count with key[1] held; press re-detected after release of reset.
    run_phase(4'b1101, 8, np, pv, dl);
    chk("midcount_no_pulse", np, 0);
    rst_n = 1'b0;
    tot = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (key_out !== 4'b0000) tot++;
    end
    chk("midcount_rst_zero", tot, 0);
    rst_n = 1'b1;
    run_phase(4'b1101, 30, np, pv, dl);
    chk("post_rst_count", np, 1);
    chk("post_rst_value", int'(pv), 2);
    chk("post_rst_delay", dl, 18);
    run_phase(4'b1111, 25, np, pv, dl);

    // Asynchronous reset drops a pulse that is already on the output.
    run_phase(4'b1110, 19, np, pv, dl);
    chk("inflight_value", int'(key_out), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_drop", int'(key_out), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_phase(4'b1110, 30, np, pv, dl);
    chk("held_thru_rst_count", np, 1);
    chk("held_thru_rst_delay", dl, 18);
    run_phase(4'b1111, 25, np, pv, dl);
    chk("final_release", np, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
